// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit frame FIFO: word layout and FSM encodings.
package eth_pkg;

    // Each FIFO word carries one byte plus an end-of-frame marker in the top bit.
    localparam int WORD_W  = 9;
    localparam int EOF_BIT = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LOAD = 2'd1,
        R_SEND = 2'd2
    } rd_state_t;

    // Build a FIFO word from a data byte and its end-of-frame flag.
    function automatic logic [WORD_W-1:0] pack_word(input logic eof, input logic [7:0] dat);
        return {eof, dat};
    endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module eth_sdp_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port and registered read port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward frame buffer feeding the MAC transmit byte stream.
// Frames are only made visible to the reader once their last byte has arrived
// cleanly; errored or overflowing frames are rolled back to the commit pointer.
module eth_tx_frame_fifo
    import eth_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 6
) (
    input  logic             clk_mac,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [7:0]       in_dat,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic             in_err,
    output logic             tx_vld,
    output logic [7:0]       tx_dat,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             tx_err,
    input  logic             tx_ack,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop_pls
);

    wr_state_t          w_state;
    rd_state_t          r_state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  cm_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               first_byte;

    logic               accept;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  wr_next;
    logic               full_hit;
    logic               frm_full;
    logic               ram_we;
    logic               commit;
    logic               drop_now;
    logic               eof_ack;
    logic               rd_issue;
    logic [WORD_W-1:0]  ram_q;

    // A byte is taken when it starts a frame (from any state) or continues one.
    // A start-of-frame always rewinds to the commit pointer, discarding any partial frame.
    assign accept   = in_vld & (in_sof | (w_state == W_RECV));
    assign wr_addr  = in_sof ? cm_ptr : wr_ptr;
    assign wr_next  = wr_addr + 1'b1;
    assign full_hit = (wr_next == rd_ptr);
    assign frm_full = &frm_cnt;
    assign ram_we   = accept & ~full_hit;

    // Committing is refused when the frame counter is saturated; that case drops like an overflow.
    assign commit   = accept & ~full_hit & in_eof & ~in_err & ~frm_full;
    assign drop_now = in_vld & in_eof &
                      ((accept & (full_hit | in_err | frm_full)) |
                       (~in_sof & (w_state == W_DROP)));

    assign eof_ack  = (r_state == R_SEND) & tx_vld & tx_ack & tx_eof;
    assign rd_issue = ((r_state == R_IDLE) & (frm_cnt != '0)) |
                      ((r_state == R_SEND) & tx_vld & tx_ack & ~tx_eof);

    assign tx_err = 1'b0;

    eth_sdp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk     (clk_mac),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (pack_word(in_eof, in_dat)),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Write side: track the frame being received, commit or roll back at its end.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            drop_cnt <= '0;
            drop_pls <= 1'b0;
        end else begin
            drop_pls <= drop_now;
            if (drop_now) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (accept) begin
                if (full_hit) begin
                    // No room: abandon the frame; if this was its last byte we are already done.
                    wr_ptr  <= cm_ptr;
                    w_state <= in_eof ? W_IDLE : W_DROP;
                end else if (in_eof) begin
                    if (commit) begin
                        cm_ptr <= wr_next;
                        wr_ptr <= wr_next;
                    end else begin
                        wr_ptr <= cm_ptr;
                    end
                    w_state <= W_IDLE;
                end else begin
                    wr_ptr  <= wr_next;
                    w_state <= W_RECV;
                end
            end else if (in_vld && in_eof && (w_state == W_DROP)) begin
                w_state <= W_IDLE;
            end
        end
    end

    // Count committed frames awaiting transmission; a commit and a final ack together cancel out.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt <= '0;
        end else begin
            case ({commit, eof_ack})
                2'b10:   frm_cnt <= frm_cnt + 1'b1;
                2'b01:   frm_cnt <= frm_cnt - 1'b1;
                default: frm_cnt <= frm_cnt;
            endcase
        end
    end

    // Read side: fetch one byte, present it, hold until acked, then fetch the next.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            rd_ptr     <= '0;
            first_byte <= 1'b0;
            tx_vld     <= 1'b0;
            tx_dat     <= '0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (frm_cnt != '0) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        first_byte <= 1'b1;
                        r_state    <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    tx_vld  <= 1'b1;
                    tx_dat  <= ram_q[7:0];
                    tx_eof  <= ram_q[EOF_BIT];
                    tx_sof  <= first_byte;
                    r_state <= R_SEND;
                end
                R_SEND: begin
                    if (tx_ack) begin
                        tx_vld <= 1'b0;
                        tx_sof <= 1'b0;
                        tx_eof <= 1'b0;
                        if (tx_eof) begin
                            r_state <= R_IDLE;
                        end else begin
                            rd_ptr     <= rd_ptr + 1'b1;
                            first_byte <= 1'b0;
                            r_state    <= R_LOAD;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Scoreboard bench for eth_tx_frame_fifo: a full-size instance (a) and a
// 64-entry instance (b) used for the overflow case.
module tb_eth_tx_frame_fifo;

    logic       clk;
    logic       rst_n;

    logic       in_vld, in_sof, in_eof, in_err, tx_ack;
    logic [7:0] in_dat;
    logic       tx_vld, tx_sof, tx_eof, tx_err;
    logic [7:0] tx_dat;
    logic [5:0] frm_cnt, drop_cnt;
    logic       drop_pls;

    logic       in_vld_b, in_sof_b, in_eof_b, in_err_b, tx_ack_b;
    logic [7:0] in_dat_b;
    logic       tx_vld_b, tx_sof_b, tx_eof_b, tx_err_b;
    logic [7:0] tx_dat_b;
    logic [5:0] frm_cnt_b, drop_cnt_b;
    logic       drop_pls_b;

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int drop_seen_b = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    eth_tx_frame_fifo #(.ADDR_W(11), .CNT_W(6)) dut_a (
        .clk_mac(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_dat(in_dat), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
        .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_err(tx_err),
        .tx_ack(tx_ack), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt), .drop_pls(drop_pls)
    );

    eth_tx_frame_fifo #(.ADDR_W(6), .CNT_W(6)) dut_b (
        .clk_mac(clk), .rst_n(rst_n),
        .in_vld(in_vld_b), .in_dat(in_dat_b), .in_sof(in_sof_b), .in_eof(in_eof_b), .in_err(in_err_b),
        .tx_vld(tx_vld_b), .tx_dat(tx_dat_b), .tx_sof(tx_sof_b), .tx_eof(tx_eof_b), .tx_err(tx_err_b),
        .tx_ack(tx_ack_b), .frm_cnt(frm_cnt_b), .drop_cnt(drop_cnt_b), .drop_pls(drop_pls_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for instance a: every accepted byte is popped and compared.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && tx_vld && tx_ack) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_a_unexpected: got byte 0x%0h sof=%0b eof=%0b, expected none", tx_dat, tx_sof, tx_eof);
            end else begin
                e = exp_a.pop_front();
                check("tx_a_byte", {21'd0, tx_sof, tx_eof, tx_err, tx_dat}, {21'd0, e[9], e[8], 1'b0, e[7:0]});
                $display("tx_a byte 0x%02h sof=%0b eof=%0b", tx_dat, tx_sof, tx_eof);
            end
        end
        if (rst_n && drop_pls) drop_seen++;
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && tx_vld_b && tx_ack_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_b_unexpected: got byte 0x%0h sof=%0b eof=%0b, expected none", tx_dat_b, tx_sof_b, tx_eof_b);
            end else begin
                e = exp_b.pop_front();
                check("tx_b_byte", {21'd0, tx_sof_b, tx_eof_b, tx_err_b, tx_dat_b}, {21'd0, e[9], e[8], 1'b0, e[7:0]});
                $display("tx_b byte 0x%02h sof=%0b eof=%0b", tx_dat_b, tx_sof_b, tx_eof_b);
            end
        end
        if (rst_n && drop_pls_b) drop_seen_b++;
    end

    task automatic send_a(input int len, input logic [7:0] base, input logic bad,
                          input logic term, input logic expect_out);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            in_vld = 1'b1;
            in_dat = base + 8'(i);
            in_sof = (i == 0);
            in_eof = term && (i == len - 1);
            in_err = in_eof & bad;
            if (expect_out) exp_a.push_back({in_sof, in_eof, in_dat});
        end
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    endtask

    task automatic send_b(input int len, input logic [7:0] base, input logic expect_out);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            in_vld_b = 1'b1;
            in_dat_b = base + 8'(i);
            in_sof_b = (i == 0);
            in_eof_b = (i == len - 1);
            in_err_b = 1'b0;
            if (expect_out) exp_b.push_back({in_sof_b, in_eof_b, in_dat_b});
        end
        @(posedge clk); #1;
        in_vld_b = 1'b0; in_sof_b = 1'b0; in_eof_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        logic done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge clk); #1;
            if (frm_cnt == 0 && !tx_vld && exp_a.size() == 0) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_idle_b(input string name);
        logic done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge clk); #1;
            if (frm_cnt_b == 0 && !tx_vld_b && exp_b.size() == 0) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic found;
        rst_n = 1'b1;
        in_vld = 0; in_dat = 0; in_sof = 0; in_eof = 0; in_err = 0; tx_ack = 1;
        in_vld_b = 0; in_dat_b = 0; in_sof_b = 0; in_eof_b = 0; in_err_b = 0; tx_ack_b = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_vld", {31'd0, tx_vld}, 0);
        check("rst_tx_dat", {24'd0, tx_dat}, 0);
        check("rst_tx_flags", {29'd0, tx_sof, tx_eof, tx_err}, 0);
        check("rst_frm_cnt", {26'd0, frm_cnt}, 0);
        check("rst_drop", {25'd0, drop_cnt, drop_pls}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 64-byte frame, latency and frame counter
        send_a(64, 8'h00, 1'b0, 1'b1, 1'b1);
        idle_a();
        check("t1_frm_cnt_after_commit", {26'd0, frm_cnt}, 1);
        check("t1_vld_n1", {31'd0, tx_vld}, 0);
        @(posedge clk); #1;
        check("t1_vld_n2", {31'd0, tx_vld}, 0);
        @(posedge clk); #1;
        check("t1_first_out", {22'd0, tx_vld, tx_sof, tx_dat}, {22'd0, 1'b1, 1'b1, 8'h00});
        wait_idle_a("t1_drain");
        check("t1_frm_cnt_end", {26'd0, frm_cnt}, 0);

        // errored frame dropped, good frame passes
        send_a(20, 8'h80, 1'b1, 1'b1, 1'b0);
        idle_a();
        check("t2_drop_pls", {31'd0, drop_pls}, 1);
        send_a(10, 8'hC0, 1'b0, 1'b1, 1'b1);
        idle_a();
        wait_idle_a("t2_drain");
        check("t2_drop_cnt", {26'd0, drop_cnt}, 1);
        check("t2_drop_pulses", drop_seen, 1);

        // three back-to-back frames with the MAC stalled
        tx_ack = 1'b0;
        send_a(60, 8'h00, 1'b0, 1'b1, 1'b1);
        send_a(60, 8'h40, 1'b0, 1'b1, 1'b1);
        send_a(60, 8'h80, 1'b0, 1'b1, 1'b1);
        idle_a();
        check("t3_frm_cnt", {26'd0, frm_cnt}, 3);
        check("t3_hold", {22'd0, tx_vld, tx_sof, tx_dat}, {22'd0, 1'b1, 1'b1, 8'h00});
        repeat (5) @(posedge clk);
        #1;
        check("t3_hold_stable", {22'd0, tx_vld, tx_sof, tx_dat}, {22'd0, 1'b1, 1'b1, 8'h00});
        tx_ack = 1'b1;
        wait_idle_a("t3_drain");

        // unterminated frame restarted by a new start-of-frame
        send_a(15, 8'h20, 1'b0, 1'b0, 1'b0);
        send_a(8, 8'hE0, 1'b0, 1'b1, 1'b1);
        idle_a();
        wait_idle_a("t4_drain");
        check("t4_drop_cnt", {26'd0, drop_cnt}, 1);

        // reset while the fifth byte of a frame is on the bus
        send_a(10, 8'h50, 1'b0, 1'b1, 1'b1);
        idle_a();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (tx_vld && tx_dat == 8'h54) found = 1'b1;
        end
        check("t5_reached_byte5", {31'd0, found}, 1);
        rst_n = 1'b0;
        #1;
        exp_a.delete();
        check("t5_rst_tx_vld", {31'd0, tx_vld}, 0);
        check("t5_rst_frm_cnt", {26'd0, frm_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_a(6, 8'hA0, 1'b0, 1'b1, 1'b1);
        idle_a();
        wait_idle_a("t5_after_reset");

        // overflow on the 64-entry instance, then a normal frame
        send_b(70, 8'h00, 1'b0);
        check("t6_drop_pls", {31'd0, drop_pls_b}, 1);
        send_b(30, 8'h40, 1'b1);
        wait_idle_b("t6_drain");
        check("t6_drop_cnt", {26'd0, drop_cnt_b}, 1);
        check("t6_drop_pulses", drop_seen_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
